fuzzy_host_seq: RTL and testbench
=================================

Name: fuzzy_host_seq

Overview:
- Host-side initiator for the type-2 fuzzy processor.
- Latches a pair of crisp 8-bit operands and drives them onto the processor's Entrada_01/Entrada_02.
- Asserts EN_REGRAS, counts rising edges of the processor's internal rule clock (Sclk_int) to track the rule sweep, then captures saida_defuzzy and returns it to the host with a done pulse.
- Sits between the system controller/testbench and Fuzzy_1.

Parameters:
- W, 8, operand and result width.
- LOAD_CYC, 2, clk_0 cycles the operands are held before EN_REGRAS rises (fuzzifier settle).
- N_CLK_INT, 2, Sclk_int rising edges to wait after enable before capture.
- CAP_DLY, 2, clk_0 cycles between the last counted edge and result capture (covers the registered defuzzifier).
- TIMEOUT, 1023, max clk_0 cycles spent in WAIT (used only with the optional feature).

Ports:
- clk_0  in  1  system clock; all logic on the rising edge.
- Srst  in  1  reset, synchronous, active-low.
- start  in  1  host request; sampled only in IDLE.
- in_a  in  W  operand 1.
- in_b  in  W  operand 2.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of each request.
- result  out  W  last captured defuzzified value.
- err  out  1  timeout flag for the last request.
- Entrada_01  out  W  to the processor's operand 1.
- Entrada_02  out  W  to the processor's operand 2.
- EN_REGRAS  out  1  rule-sweep enable to the processor.
- Sclk_int  in  1  processor's internal rule clock, treated as data and sampled on clk_0.
- saida_defuzzy  in  W  processor's crisp output.

Behaviour:
- Reset (Srst=0 at a clk_0 edge):
  - state=IDLE.
  - busy=0, done=0, err=0, result=0, EN_REGRAS=0, Entrada_01=0, Entrada_02=0.
  - Edge-detect register=0; all counters=0.
- Edge detect: edge = Sclk_int & ~prev; prev <= Sclk_int every cycle.
  - If Sclk_int is already high on the first cycle out of reset, that cycle does not count as an edge.
- IDLE:
  - On start=1: Entrada_01<=in_a, Entrada_02<=in_b, err<=0, cnt<=0, go LOAD.
  - busy rises on the following cycle.
- LOAD:
  - Increment cnt; when cnt==LOAD_CYC-1, go ENABLE.
  - Entrada_* stay frozen from here until the next IDLE accept.
- ENABLE (1 cycle): EN_REGRAS<=1, edge count<=0, timer<=0, go WAIT.
- WAIT:
  - EN_REGRAS stays 1.
  - Increment the edge count on each detected edge; when it reaches N_CLK_INT, cnt<=0, go CAPTURE.
- CAPTURE:
  - Count CAP_DLY cycles.
  - On the final cycle: result<=saida_defuzzy, EN_REGRAS<=0, go DONE.
- DONE (1 cycle): done=1, go IDLE. busy is still 1 during DONE.
- Latency, ideal case with Sclk_int edges immediately available: start to done = 1 + LOAD_CYC + 1 + (cycles to N_CLK_INT edges) + CAP_DLY + 1.
- start while busy: ignored, with no queueing.
- start held high continuously: a new request is accepted on the first IDLE cycle after DONE (back-to-back operation).
- Srst=0 mid-request: abort to the reset values above on that edge, including EN_REGRAS=0. No done pulse.
- Counter widths: each counter must hold its parameter value without wrap (use $clog2(param+1)).
- result holds its value between requests and changes only in CAPTURE.

Optional Feature:
- Macro FUZZY_SEQ_TIMEOUT_EN.
- When defined:
  - A timer counts clk_0 cycles in WAIT.
  - If the timer reaches TIMEOUT before N_CLK_INT edges arrive: EN_REGRAS<=0, err<=1, go DONE (done pulses).
  - result is left unchanged; err holds until the next accepted start.
  - If the final edge and the timer expiry land on the same cycle, the edge wins: go CAPTURE, err=0.
- When undefined:
  - No timer logic; WAIT waits indefinitely.
  - err is tied to 0.

Test Plan:
- Reset then idle: Srst low 3 cycles, release -> every output 0, busy=0, no done for 50 cycles with start=0.
- Nominal, defaults: in_a=0x40, in_b=0xC0 -> Entrada_01=0x40, Entrada_02=0xC0. EN_REGRAS rises 4 cycles after start. Drive Sclk_int as a 4-cycle-period square wave and saida_defuzzy=0x7A -> result=0x7A, one-cycle done, err=0, EN_REGRAS back to 0.
- Busy rejection: during WAIT, pulse start with in_a=0x11 -> Entrada_01 remains 0x40 and exactly one done is seen.
- Reset mid-WAIT: assert Srst for 1 cycle while EN_REGRAS=1 -> EN_REGRAS=0 and result=0 next cycle, no done; then a new start completes normally.
- Sclk_int high at reset release, then held high -> no edge counted and no capture (with FUZZY_SEQ_TIMEOUT_EN, TIMEOUT=20: done with err=1 at 20 WAIT cycles, result unchanged).
- Back-to-back: start held high, operands changed to 0x05/0x06 after the first done -> second request accepted on the cycle after DONE, Entrada_01=0x05, result updated to the new saida_defuzzy.

Source files
------------

// File: rtl/fuzzy_host_seq.sv
// fuzzy_host_seq: host-side sequencer that loads operands, sweeps Fuzzy_1 rules via Sclk_int edges and returns the defuzzified result.
// Define FUZZY_SEQ_TIMEOUT_EN to add a WAIT-state timeout that sets err and ends the request.
module fuzzy_host_seq #(
  parameter int W         = 8,
  parameter int LOAD_CYC  = 2,
  parameter int N_CLK_INT = 2,
  parameter int CAP_DLY   = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic         clk_0,
  input  logic         Srst,
  input  logic         start,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err,
  output logic [W-1:0] Entrada_01,
  output logic [W-1:0] Entrada_02,
  output logic         EN_REGRAS,
  input  logic         Sclk_int,
  input  logic [W-1:0] saida_defuzzy
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENABLE, S_WAIT, S_CAPTURE, S_DONE} state_t;
  localparam int CM = LOAD_CYC > CAP_DLY ? LOAD_CYC : CAP_DLY;
  localparam int CW = $clog2(CM + 1);
  localparam int EW = $clog2(N_CLK_INT + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [EW-1:0] ecnt;
  logic          prev;
  logic          sclk_rise;
  logic          last_edge;
  assign sclk_rise = Sclk_int & ~prev;
  assign last_edge = sclk_rise && (ecnt == EW'(N_CLK_INT - 1));
  assign busy      = state != S_IDLE;
`ifdef FUZZY_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  logic          err_q;
  logic          expire;
  assign expire = timer == TW'(TIMEOUT - 1);
  assign err    = err_q;
  // a final edge arriving on the expiry cycle takes priority over the timeout
  always_ff @(posedge clk_0)
    if (!Srst) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      timer <= state == S_ENABLE ? '0 : state == S_WAIT ? timer + 1'b1 : timer;
      err_q <= (state == S_IDLE && start) ? 1'b0 :
               (state == S_WAIT && !last_edge && expire) ? 1'b1 : err_q;
    end
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk_0)
    if (!Srst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      result     <= '0;
      EN_REGRAS  <= 1'b0;
      Entrada_01 <= '0;
      Entrada_02 <= '0;
      prev       <= 1'b0;
      cnt        <= '0;
      ecnt       <= '0;
    end else begin
      prev <= Sclk_int;
      done <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            Entrada_01 <= in_a;
            Entrada_02 <= in_b;
            cnt        <= '0;
            state      <= S_LOAD;
          end
        S_LOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(LOAD_CYC - 1)) state <= S_ENABLE;
        end
        S_ENABLE: begin
          EN_REGRAS <= 1'b1;
          ecnt      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT:
          if (last_edge) begin
            ecnt  <= ecnt + 1'b1;
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            if (sclk_rise) ecnt <= ecnt + 1'b1;
`ifdef FUZZY_SEQ_TIMEOUT_EN
            if (expire) begin
              EN_REGRAS <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
`endif
          end
        S_CAPTURE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(CAP_DLY - 1)) begin
            result    <= saida_defuzzy;
            EN_REGRAS <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fuzzy_host_seq.sv
// tb_fuzzy_host_seq: directed plus randomized checks of fuzzy_host_seq against a cycle-timeline reference model.
module tb_fuzzy_host_seq;
  localparam int W = 8, LC = 2, NC = 2, CD = 2, TO = 20;
  logic         clk_0 = 1'b0, Srst = 1'b0, start = 1'b0, Sclk_int = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, saida_defuzzy = '0;
  logic         busy, done, err, EN_REGRAS;
  logic [W-1:0] result, Entrada_01, Entrada_02;
  int           tests = 0, fails = 0, cyc = 0, done_cnt = 0;
  logic         hist [0:16383];
  logic [W-1:0] model_result = '0;

  fuzzy_host_seq #(.W(W), .LOAD_CYC(LC), .N_CLK_INT(NC), .CAP_DLY(CD), .TIMEOUT(TO)) dut (
    .clk_0(clk_0), .Srst(Srst), .start(start), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .result(result), .err(err),
    .Entrada_01(Entrada_01), .Entrada_02(Entrada_02), .EN_REGRAS(EN_REGRAS),
    .Sclk_int(Sclk_int), .saida_defuzzy(saida_defuzzy)
  );

  always #5 clk_0 = ~clk_0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // hist[k] is the Sclk_int value the DUT samples at rising edge k
  task automatic tick();
    hist[cyc + 1] = Sclk_int;
    @(posedge clk_0);
    #1;
    cyc++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] val,
                         input int mode, input bit inject, input bit hold);
    int acc, wait0, ecount, exp_done, got_done, dc0;
    logic exp_err;
    in_a = a; in_b = b; saida_defuzzy = val; start = 1'b1; dc0 = done_cnt;
    tick();
    acc = cyc;
    if (!hold) start = 1'b0;
    chk("accept_entrada_01", Entrada_01, a);
    chk("accept_entrada_02", Entrada_02, b);
    chk("accept_busy", busy, 1);
    wait0 = acc + LC + 2; ecount = 0; exp_done = -1; got_done = -1; exp_err = 1'b0;
    while (got_done < 0 && cyc - acc < 200) begin
      Sclk_int = mode == 0 ? 1'($urandom % 2) : mode == 1 ? 1'((cyc >> 1) & 1) : 1'b1;
      start = hold || (inject && cyc + 1 == wait0 + 1);
      if (inject && cyc + 1 == wait0 + 1) in_a = 8'h11;
      tick();
      if (cyc == acc + LC) chk("en_before_enable", EN_REGRAS, 0);
      if (cyc == acc + LC + 1) chk("en_rise", EN_REGRAS, 1);
      if (cyc >= wait0 && exp_done < 0) begin
        if (hist[cyc] && !hist[cyc - 1]) ecount++;
        if (ecount == NC) exp_done = cyc + CD;
`ifdef FUZZY_SEQ_TIMEOUT_EN
        else if (cyc - wait0 + 1 == TO) begin
          exp_done = cyc;
          exp_err  = 1'b1;
        end
`endif
      end
      if (done) got_done = cyc;
    end
    if (!hold) start = 1'b0;
    chk("done_cycle", got_done, exp_done);
    if (got_done >= 0) begin
      if (!exp_err) model_result = val;
      chk("result", result, model_result);
      chk("err", err, exp_err);
      chk("en_after_done", EN_REGRAS, 0);
      chk("busy_in_done", busy, 1);
      chk("single_done", done_cnt - dc0, 1);
      chk("entrada_frozen", Entrada_01, a);
      if (!hold) begin
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end
    end
  endtask

  initial begin
    Srst = 1'b0;
    repeat (3) tick();
    Srst = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_en", EN_REGRAS, 0);
    chk("rst_e1", Entrada_01, 0);
    chk("rst_e2", Entrada_02, 0);
    repeat (50) tick();
    chk("idle_no_done", done_cnt, 0);
    chk("idle_busy50", busy, 0);

    run_req(8'h40, 8'hC0, 8'h7A, 1, 1'b0, 1'b0);
    run_req(8'h40, 8'hC0, 8'h3C, 0, 1'b1, 1'b0);
    repeat (6) run_req(8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, 1'b0);

    begin : mid_wait_reset
      int dc;
      in_a = 8'h21; in_b = 8'h42; saida_defuzzy = 8'hAA; Sclk_int = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && EN_REGRAS !== 1'b1; i++) tick();
      chk("midwait_en_high", EN_REGRAS, 1);
      tick();
      Srst = 1'b0;
      tick();
      Srst = 1'b1;
      chk("midwait_en", EN_REGRAS, 0);
      chk("midwait_result", result, 0);
      chk("midwait_busy", busy, 0);
      chk("midwait_e1", Entrada_01, 0);
      model_result = '0;
      dc = done_cnt;
      repeat (10) tick();
      chk("midwait_no_done", done_cnt - dc, 0);
    end
    run_req(8'h12, 8'h34, 8'h56, 1, 1'b0, 1'b0);

    Sclk_int = 1'b1; Srst = 1'b0;
    tick(); tick();
    Srst = 1'b1;
    model_result = '0;
    run_req(8'h22, 8'h33, 8'h99, 2, 1'b0, 1'b0);
    Srst = 1'b0;
    tick();
    Srst = 1'b1;
    model_result = '0;
    Sclk_int = 1'b0;
    tick();

    run_req(8'h40, 8'hC0, 8'h7A, 1, 1'b0, 1'b1);
    in_a = 8'h05; in_b = 8'h06; saida_defuzzy = 8'h5D;
    tick();
    chk("b2b_idle_busy", busy, 0);
    run_req(8'h05, 8'h06, 8'h5D, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
